phase_error_detector: RTL and testbench

Counter-based digital phase detector that sits directly upstream of the ADPLL loop filter. It measures the time between a reference edge and a feedback (divided-DCO) edge in `gen_clk_i` cycles. It emits a signed, saturated error word plus a one-cycle valid strobe per comparison, and the loop filter consumes that error. An optional lock detector flags steady-state convergence.

---
 rtl/phase_error_detector.sv | 210 +++++++++++++++++++++
 tb/tb_phase_error_detector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/phase_error_detector.sv
// ============================================================================
// Module   : phase_error_detector
// Purpose  : Counter-based ref/feedback phase detector for the ADPLL loop
//            filter. Optional lock detector enabled by PED_LOCK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_error_detector #(
   parameter int ERROR_WIDTH = 8,
   parameter int LOCK_TOL    = 2,
   parameter int LOCK_COUNT  = 16
) (
   input  logic                          gen_clk_i,
   input  logic                          reset_n_i,
   input  logic                          ref_i,
   input  logic                          fb_i,
   output logic signed [ERROR_WIDTH-1:0] error_o,
   output logic                          error_valid_o,
   output logic                          lock_o
);

   localparam int CW = ERROR_WIDTH - 1;

   localparam logic        [CW-1:0]          c_MAXE     = {CW{1'b1}};
   localparam logic signed [ERROR_WIDTH-1:0] c_ZERO     = '0;
   localparam logic signed [ERROR_WIDTH-1:0] c_POS_MAX  = {1'b0, c_MAXE};
   localparam logic signed [ERROR_WIDTH-1:0] c_NEG_MAX  = c_ZERO - c_POS_MAX;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REF_LEAD = 3'd1,
      S_FB_LEAD  = 3'd2,
      S_SLIP_REF = 3'd3,
      S_SLIP_FB  = 3'd4
   } state_t;

   logic ref_s1_q, ref_s2_q, ref_prev_q, ref_p_q;
   logic fb_s1_q,  fb_s2_q,  fb_prev_q,  fb_p_q;

   state_t                          state_q, state_d;
   logic        [CW-1:0]            cnt_q, cnt_d;
   logic        [CW-1:0]            cnt_inc;
   logic signed [ERROR_WIDTH-1:0]   mag;
   logic                            emit;
   logic signed [ERROR_WIDTH-1:0]   emit_val;
   logic signed [ERROR_WIDTH-1:0]   error_q, error_d;
   logic                            valid_q;

   // Edge pulses are registered so the FSM sees them 3 cycles after the input edge.
   always_ff @(posedge gen_clk_i) begin
      if (!reset_n_i) begin
         ref_s1_q   <= 1'b0;
         ref_s2_q   <= 1'b0;
         ref_prev_q <= 1'b0;
         ref_p_q    <= 1'b0;
         fb_s1_q    <= 1'b0;
         fb_s2_q    <= 1'b0;
         fb_prev_q  <= 1'b0;
         fb_p_q     <= 1'b0;
      end else begin
         ref_s1_q   <= ref_i;
         ref_s2_q   <= ref_s1_q;
         ref_prev_q <= ref_s2_q;
         ref_p_q    <= ref_s2_q & ~ref_prev_q;
         fb_s1_q    <= fb_i;
         fb_s2_q    <= fb_s1_q;
         fb_prev_q  <= fb_s2_q;
         fb_p_q     <= fb_s2_q & ~fb_prev_q;
      end
   end

   assign cnt_inc = cnt_q + 1'b1;
   assign mag     = {1'b0, cnt_inc};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      emit     = 1'b0;
      emit_val = c_ZERO;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (ref_p_q && fb_p_q) begin
               emit = 1'b1;
            end else if (ref_p_q) begin
               state_d = S_REF_LEAD;
            end else if (fb_p_q) begin
               state_d = S_FB_LEAD;
            end
         end
         S_REF_LEAD: begin
            if (fb_p_q) begin
               // A coincident ref edge immediately opens the next measurement.
               emit     = 1'b1;
               emit_val = mag;
               cnt_d    = '0;
               state_d  = ref_p_q ? S_REF_LEAD : S_IDLE;
            end else if (ref_p_q) begin
               emit     = 1'b1;
               emit_val = c_POS_MAX;
               cnt_d    = '0;
            end else if (cnt_inc == c_MAXE) begin
               emit     = 1'b1;
               emit_val = c_POS_MAX;
               cnt_d    = '0;
               state_d  = S_SLIP_REF;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_FB_LEAD: begin
            if (ref_p_q) begin
               emit     = 1'b1;
               emit_val = c_ZERO - mag;
               cnt_d    = '0;
               state_d  = fb_p_q ? S_FB_LEAD : S_IDLE;
            end else if (fb_p_q) begin
               emit     = 1'b1;
               emit_val = c_NEG_MAX;
               cnt_d    = '0;
            end else if (cnt_inc == c_MAXE) begin
               emit     = 1'b1;
               emit_val = c_NEG_MAX;
               cnt_d    = '0;
               state_d  = S_SLIP_FB;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_SLIP_REF: begin
            cnt_d = '0;
            if (fb_p_q) begin
               state_d = S_IDLE;
            end
         end
         S_SLIP_FB: begin
            cnt_d = '0;
            if (ref_p_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign error_d = emit ? emit_val : error_q;

   always_ff @(posedge gen_clk_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         error_q <= c_ZERO;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         error_q <= error_d;
         valid_q <= emit;
      end
   end

   assign error_o       = error_q;
   assign error_valid_o = valid_q;

`ifdef PED_LOCK_DETECT_EN
   localparam logic signed [ERROR_WIDTH-1:0] c_TOL_POS = ERROR_WIDTH'(LOCK_TOL);
   localparam logic signed [ERROR_WIDTH-1:0] c_TOL_NEG = c_ZERO - c_TOL_POS;
   localparam logic        [7:0]             c_LOCK_N  = 8'(LOCK_COUNT);

   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic       lock_q;
   logic       in_lock;

   // Slips and timeouts emit +/-MAXE; excluding those values makes them always clear lock.
   assign in_lock = (emit_val >= c_TOL_NEG) && (emit_val <= c_TOL_POS) &&
                    (emit_val != c_POS_MAX) && (emit_val != c_NEG_MAX);

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (emit) begin
         if (!in_lock) begin
            lock_cnt_d = '0;
         end else if (lock_cnt_q != c_LOCK_N) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge gen_clk_i) begin
      if (!reset_n_i) begin
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= (lock_cnt_d == c_LOCK_N);
      end
   end

   assign lock_o = lock_q;
`else
   assign lock_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_phase_error_detector.sv
// ============================================================================
// Module   : tb_phase_error_detector
// Purpose  : Directed, table-driven self-checking bench for phase_error_detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_error_detector;

`ifdef PED_LOCK_DETECT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic              clk     = 1'b0;
   logic              reset_n = 1'b0;
   logic              ref_in  = 1'b0;
   logic              fb_in   = 1'b0;
   logic signed [7:0] err;
   logic              vld;
   logic              lock;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   typedef struct {
      int err;
      int cyc;
      bit lock;
   } pulse_t;

   typedef struct {
      bit ref_first;
      int gap;
      int exp_err;
   } vec_t;

   pulse_t pq[$];
   vec_t   vecs[8];

   phase_error_detector #(
      .ERROR_WIDTH(8),
      .LOCK_TOL   (2),
      .LOCK_COUNT (16)
   ) dut (
      .gen_clk_i    (clk),
      .reset_n_i    (reset_n),
      .ref_i        (ref_in),
      .fb_i         (fb_in),
      .error_o      (err),
      .error_valid_o(vld),
      .lock_o       (lock)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vld) pq.push_back('{int'(err), cyc, lock});
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_one(input string name, input int exp_err, input int exp_cyc,
                            input bit exp_lock);
      chk({name, " count"}, pq.size(), 1);
      if (pq.size() > 0) begin
         chk({name, " value"}, pq[0].err, exp_err);
         chk({name, " cycle"}, pq[0].cyc, exp_cyc);
         chk({name, " lock"}, int'(pq[0].lock), int'(exp_lock));
      end
      pq.delete();
   endtask

   task automatic run_pair(input bit ref_first, input int gap, output int e_close);
      @(negedge clk);
      if (gap == 0) begin
         ref_in = 1'b1;
         fb_in  = 1'b1;
      end else begin
         if (ref_first) ref_in = 1'b1; else fb_in = 1'b1;
         repeat (gap) @(negedge clk);
         if (ref_first) fb_in = 1'b1; else ref_in = 1'b1;
      end
      e_close = cyc;
      repeat (8) @(negedge clk);
      ref_in = 1'b0;
      fb_in  = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      int ec, e0, e1, e2;

      vecs[0] = '{1'b1,   5,    5};
      vecs[1] = '{1'b0,  12,  -12};
      vecs[2] = '{1'b1,   0,    0};
      vecs[3] = '{1'b1,   1,    1};
      vecs[4] = '{1'b0,   1,   -1};
      vecs[5] = '{1'b1,   3,    3};
      vecs[6] = '{1'b1, 126,  126};
      vecs[7] = '{1'b0, 127, -127};

      reset_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset error", int'(err), 0);
      chk("reset valid", int'(vld), 0);
      chk("reset lock",  int'(lock), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle no pulse", pq.size(), 0);

      for (int i = 0; i < 8; i++) begin
         run_pair(vecs[i].ref_first, vecs[i].gap, ec);
         check_one($sformatf("vec%0d", i), vecs[i].exp_err, ec + 4, 1'b0);
         chk($sformatf("vec%0d hold", i), int'(err), vecs[i].exp_err);
      end

      // Timeout: ref leads with no feedback for 200 cycles.
      @(negedge clk);
      ref_in = 1'b1;
      e0 = cyc;
      repeat (200) @(negedge clk);
      fb_in = 1'b1;
      repeat (8) @(negedge clk);
      ref_in = 1'b0;
      fb_in  = 1'b0;
      repeat (6) @(negedge clk);
      check_one("timeout", 127, e0 + 131, 1'b0);
      run_pair(1'b1, 3, ec);
      check_one("after timeout", 3, ec + 4, 1'b0);

      // Cycle slip: two ref edges 40 cycles apart, then fb 6 cycles later.
      @(negedge clk);
      ref_in = 1'b1;
      repeat (10) @(negedge clk);
      ref_in = 1'b0;
      repeat (30) @(negedge clk);
      ref_in = 1'b1;
      e1 = cyc;
      repeat (6) @(negedge clk);
      fb_in = 1'b1;
      e2 = cyc;
      repeat (8) @(negedge clk);
      ref_in = 1'b0;
      fb_in  = 1'b0;
      repeat (6) @(negedge clk);
      chk("slip count", pq.size(), 2);
      if (pq.size() == 2) begin
         chk("slip value",  pq[0].err, 127);
         chk("slip cycle",  pq[0].cyc, e1 + 4);
         chk("close value", pq[1].err, 6);
         chk("close cycle", pq[1].cyc, e2 + 4);
      end
      pq.delete();

      // Lock acquisition, saturation, and loss.
      for (int i = 0; i < 17; i++) begin
         run_pair(1'b1, 1, ec);
         check_one($sformatf("lockpair%0d", i), 1, ec + 4, LOCK_EN && (i >= 15));
      end
      run_pair(1'b1, 9, ec);
      check_one("lock loss", 9, ec + 4, 1'b0);

      // Reset three cycles into a REF_LEAD measurement.
      @(negedge clk);
      ref_in = 1'b1;
      repeat (6) @(negedge clk);
      reset_n = 1'b0;
      ref_in  = 1'b0;
      repeat (3) @(negedge clk);
      chk("midreset error", int'(err), 0);
      chk("midreset valid", int'(vld), 0);
      chk("midreset lock",  int'(lock), 0);
      chk("midreset no pulse", pq.size(), 0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post reset no pulse", pq.size(), 0);
      run_pair(1'b1, 4, ec);
      check_one("post reset pair", 4, ec + 4, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
